// File: rtl/tx_pkg.sv
// Shared types and default constants for the BPSK pulse transmitter.
package tx_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SPS   = 8;
    localparam int DEF_DUTY  = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } tx_state_t;

    typedef logic signed [DEF_WIDTH-1:0] sample_t;

endpackage

// File: rtl/tx_sample_fifo.sv
// Small synchronous sample FIFO with asynchronous active-low reset.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module tx_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/bpsk_pulse_tx.sv
// BPSK pulse transmitter: queues samples and holds each for SPS clocks with a
// programmable duty. Define TX_UNDERRUN_CNT_EN to add the underrun_cnt output.
module bpsk_pulse_tx
    import tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SPS   = DEF_SPS,
    parameter int DUTY  = DEF_DUTY,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] bpsk_out,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    trans_start,
    output logic signed [WIDTH-1:0] trans_out,
    output logic                    trans_rdy,
    output logic                    sym_strobe,
    output logic                    busy
`ifdef TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]             underrun_cnt
`endif
);

    localparam int PW = $clog2(SPS);
    localparam logic [PW-1:0] LAST = PW'(SPS - 1);

    tx_state_t               state, state_n;
    logic [PW-1:0]           phase, phase_n;
    logic signed [WIDTH-1:0] sample, sample_n;
    logic signed [WIDTH-1:0] out_n;
    logic                    rdy_n;
    logic                    strobe_n;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [WIDTH-1:0]        head;

    tx_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .wdata (bpsk_out),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign in_ready = !full;
    assign busy     = (state == HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            phase      <= '0;
            sample     <= '0;
            trans_out  <= '0;
            trans_rdy  <= 1'b0;
            sym_strobe <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            sample     <= sample_n;
            trans_out  <= out_n;
            trans_rdy  <= rdy_n;
            sym_strobe <= strobe_n;
        end
    end

    // Output registers are loaded with the value belonging to the next phase,
    // so a pop at a boundary starts the new symbol without an idle clock.
    always_comb begin
        state_n  = state;
        phase_n  = phase;
        sample_n = sample;
        out_n    = '0;
        rdy_n    = 1'b0;
        strobe_n = 1'b0;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (trans_start && !empty) begin
                    pop      = 1'b1;
                    sample_n = head;
                    phase_n  = '0;
                    state_n  = HOLD;
                    out_n    = head;
                    rdy_n    = 1'b1;
                    strobe_n = 1'b1;
                end
            end
            HOLD: begin
                if (phase == LAST) begin
                    if (trans_start && !empty) begin
                        pop      = 1'b1;
                        sample_n = head;
                        phase_n  = '0;
                        out_n    = head;
                        rdy_n    = 1'b1;
                        strobe_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        phase_n = '0;
                    end
                end else begin
                    phase_n = phase + 1'b1;
                    rdy_n   = 1'b1;
                    out_n   = ((int'(phase) + 1) < DUTY) ? sample : '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef TX_UNDERRUN_CNT_EN
    logic underrun;

    assign underrun = (state == HOLD) && (phase == LAST) && trans_start && empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun_cnt <= '0;
        end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bpsk_pulse_tx.sv
// Self-checking bench: NRZ (DUTY=4) and RZ (DUTY=2) instances share stimulus
// and are compared each clock against a queue-based symbol model.
module tb_bpsk_pulse_tx;

    localparam int WIDTH  = 16;
    localparam int SPS    = 4;
    localparam int DEPTH  = 4;
    localparam int DUTY_A = 4;
    localparam int DUTY_B = 2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic signed [WIDTH-1:0] bpsk_out = '0;
    logic                    in_valid = 1'b0;
    logic                    trans_start = 1'b0;

    logic                    in_ready_a, in_ready_b;
    logic signed [WIDTH-1:0] trans_out_a, trans_out_b;
    logic                    trans_rdy_a, trans_rdy_b;
    logic                    sym_strobe_a, sym_strobe_b;
    logic                    busy_a, busy_b;
`ifdef TX_UNDERRUN_CNT_EN
    logic [15:0]             ucnt_a, ucnt_b;
`endif

    int tests = 0;
    int fails = 0;

    logic signed [WIDTH-1:0] q[$];
    logic signed [WIDTH-1:0] cur = '0;
    int                      pos = -1;
    logic                    m_strobe = 1'b0;
    int                      m_under = 0;

    always #5 clk = ~clk;

    bpsk_pulse_tx #(.WIDTH(WIDTH), .SPS(SPS), .DUTY(DUTY_A), .DEPTH(DEPTH)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .bpsk_out    (bpsk_out),
        .in_valid    (in_valid),
        .in_ready    (in_ready_a),
        .trans_start (trans_start),
        .trans_out   (trans_out_a),
        .trans_rdy   (trans_rdy_a),
        .sym_strobe  (sym_strobe_a),
        .busy        (busy_a)
`ifdef TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(ucnt_a)
`endif
    );

    bpsk_pulse_tx #(.WIDTH(WIDTH), .SPS(SPS), .DUTY(DUTY_B), .DEPTH(DEPTH)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .bpsk_out    (bpsk_out),
        .in_valid    (in_valid),
        .in_ready    (in_ready_b),
        .trans_start (trans_start),
        .trans_out   (trans_out_b),
        .trans_rdy   (trans_rdy_b),
        .sym_strobe  (sym_strobe_b),
        .busy        (busy_b)
`ifdef TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(ucnt_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of the reference: a symbol lasts SPS clocks, the next one is
    // taken only if start is high at the end and something was already queued.
    task automatic modelEdge();
        bit can_pop;
        bit do_push;
        can_pop  = (q.size() > 0);
        do_push  = in_valid && (q.size() < DEPTH);
        m_strobe = 1'b0;
        if (pos < 0 || pos == SPS - 1) begin
            if (trans_start && can_pop) begin
                cur      = q.pop_front();
                pos      = 0;
                m_strobe = 1'b1;
            end else begin
                if (pos == SPS - 1 && trans_start) m_under++;
                pos = -1;
            end
        end else begin
            pos++;
        end
        if (do_push) q.push_back(bpsk_out);
    endtask

    task automatic checkOutput();
        logic signed [WIDTH-1:0] exp_a;
        logic signed [WIDTH-1:0] exp_b;
        exp_a = (pos >= 0 && pos < DUTY_A) ? cur : '0;
        exp_b = (pos >= 0 && pos < DUTY_B) ? cur : '0;
        check("trans_out_nrz", trans_out_a, exp_a);
        check("trans_out_rz", trans_out_b, exp_b);
        check("trans_rdy_nrz", trans_rdy_a, pos >= 0);
        check("trans_rdy_rz", trans_rdy_b, pos >= 0);
        check("sym_strobe", sym_strobe_a, m_strobe);
        check("sym_strobe_rz", sym_strobe_b, m_strobe);
        check("busy", busy_a, pos >= 0);
        check("in_ready", in_ready_a, q.size() < DEPTH);
        check("in_ready_rz", in_ready_b, q.size() < DEPTH);
`ifdef TX_UNDERRUN_CNT_EN
        check("underrun_cnt", ucnt_a, m_under);
        check("underrun_cnt_rz", ucnt_b, m_under);
`endif
    endtask

    task automatic applyStimulus(input logic v, input logic signed [WIDTH-1:0] d, input logic s);
        in_valid    = v;
        bpsk_out    = d;
        trans_start = s;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #2;
        checkOutput();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // NRZ back-to-back pair, then underrun when the queue runs dry.
        applyStimulus(1'b1, 16'sd1000, 1'b0);
        applyStimulus(1'b1, -16'sd1000, 1'b0);
        for (int i = 0; i < 11; i++) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);

        // Single RZ symbol with start held, giving a second underrun.
        applyStimulus(1'b1, 16'sd500, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);

        // Fill the FIFO, hold off a fifth push, then release it by popping.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 16'(100 + i), 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'sd777, 1'b1);
        for (int i = 0; i < 24; i++) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);

        // Asynchronous reset in the middle of a symbol.
        applyStimulus(1'b1, 16'sd321, 1'b0);
        applyStimulus(1'b1, -16'sd321, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
        reset = 1'b0;
        q.delete();
        pos      = -1;
        m_strobe = 1'b0;
        m_under  = 0;
        #1;
        checkOutput();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);

        // Drop start at phase 1 with two samples still queued.
        applyStimulus(1'b1, 16'sd11, 1'b0);
        applyStimulus(1'b1, 16'sd22, 1'b0);
        applyStimulus(1'b1, 16'sd33, 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom),
                          ($urandom_range(0, 9) < 8));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
